seq_nrdiv_sm: RTL and testbench

- Parametrised, sequential sign-magnitude non-restoring divider. Successor to the combinational CAS-array divider.
- Divides a 2N-bit dividend magnitude by an N-bit divisor magnitude, producing one quotient bit per clock.
- Start/busy/done handshake; divide-by-zero and quotient-overflow flags; negative-zero normalisation.
- Sits in the datapath wherever a multicycle divide is acceptable, in place of the large combinational array.

---
 rtl/seq_nrdiv_sm_if.sv | 29 ++
 rtl/seq_nrdiv_sm.sv | 157 +++++++++++++++
 tb/tb_seq_nrdiv_sm.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_nrdiv_sm_if.sv
// Operand/result bundle for seq_nrdiv_sm: start/busy/done handshake plus the
// sign-magnitude dividend, divisor, quotient, remainder and error flags.
interface seq_nrdiv_sm_if #(
  parameter int N = 5
);
  logic           start;
  logic [2*N-1:0] X;
  logic [N-1:0]   Y;
  logic           X_sign;
  logic           Y_sign;
  logic           busy;
  logic           done;
  logic [N-1:0]   Q;
  logic [N-1:0]   R;
  logic           Q_sign;
  logic           R_sign;
  logic           div_zero;
  logic           ovf;

  modport master (
    output start, X, Y, X_sign, Y_sign,
    input  busy, done, Q, R, Q_sign, R_sign, div_zero, ovf
  );

  modport slave (
    input  start, X, Y, X_sign, Y_sign,
    output busy, done, Q, R, Q_sign, R_sign, div_zero, ovf
  );
endinterface

// File: rtl/seq_nrdiv_sm.sv
// Sequential sign-magnitude non-restoring divider: 2N-bit dividend magnitude by
// N-bit divisor magnitude, one quotient bit per clock, with zero/overflow flags.
module seq_nrdiv_sm #(
  parameter int N = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_nrdiv_sm_if.slave bus
);

  localparam int PW = N + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_p;
  logic [N-1:0]   r_x_lo;
  logic [N-1:0]   r_y;
  logic           r_x_sign;
  logic           r_y_sign;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  r_cnt;
  logic           r_err_dz;
  logic           r_err_ovf;

  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_q_out;
  logic [N-1:0]   r_r_out;
  logic           r_q_sign;
  logic           r_r_sign;
  logic           r_div_zero;
  logic           r_ovf;

  logic [PW-1:0]  w_y_ext;
  logic [PW-1:0]  w_p_shift;
  logic [PW-1:0]  w_p_step;
  logic [N-1:0]   w_r_fix;

  assign w_y_ext   = {2'b00, r_y};
  assign w_p_shift = {r_p[PW-2:0], r_x_lo[N-1]};
  // Non-restoring step: the sign of the previous partial remainder picks add or subtract.
  assign w_p_step  = r_p[PW-1] ? (w_p_shift + w_y_ext) : (w_p_shift - w_y_ext);
  // Final correction only needs the low N bits: the fixed remainder is known to be in [0, Y).
  assign w_r_fix   = r_p[PW-1] ? (r_p[N-1:0] + r_y) : r_p[N-1:0];

  // NOTE: every register here is updated with <= so all state advances together on the edge;
  // a blocking = would let later statements see half-updated values and break the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_x_lo     <= '0;
      r_y        <= '0;
      r_x_sign   <= 1'b0;
      r_y_sign   <= 1'b0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_err_dz   <= 1'b0;
      r_err_ovf  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q_out    <= '0;
      r_r_out    <= '0;
      r_q_sign   <= 1'b0;
      r_r_sign   <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_p       <= {2'b00, bus.X[2*N-1:N]};
            r_x_lo    <= bus.X[N-1:0];
            r_y       <= bus.Y;
            r_x_sign  <= bus.X_sign;
            r_y_sign  <= bus.Y_sign;
            r_err_dz  <= 1'b0;
            r_err_ovf <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_CHECK;
          end else begin
            r_state   <= S_IDLE;
          end
        end

        // Errors take the FIX cycle too, so every result is published from one place.
        S_CHECK: begin
          if (r_y == '0) begin
            r_err_dz  <= 1'b1;
            r_state   <= S_FIX;
          end else if (r_p[N-1:0] >= r_y) begin
            r_err_ovf <= 1'b1;
            r_state   <= S_FIX;
          end else begin
            r_p       <= r_p - w_y_ext;
            r_cnt     <= CW'(N);
            r_state   <= S_ITER;
          end
        end

        S_ITER: begin
          r_p    <= w_p_step;
          r_x_lo <= {r_x_lo[N-2:0], 1'b0};
          r_q    <= {r_q[N-2:0], ~w_p_step[PW-1]};
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_div_zero <= r_err_dz;
          r_ovf      <= r_err_ovf;
          if (r_err_dz || r_err_ovf) begin
            r_q_out  <= '0;
            r_r_out  <= '0;
            r_q_sign <= 1'b0;
            r_r_sign <= 1'b0;
          end else begin
            r_q_out  <= r_q;
            r_r_out  <= w_r_fix;
            r_q_sign <= (r_x_sign ^ r_y_sign) & (|r_q);
            r_r_sign <= r_x_sign & (|w_r_fix);
          end
          r_state    <= S_DONE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.Q        = r_q_out;
  assign bus.R        = r_r_out;
  assign bus.Q_sign   = r_q_sign;
  assign bus.R_sign   = r_r_sign;
  assign bus.div_zero = r_div_zero;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_seq_nrdiv_sm.sv
// Self-checking bench for seq_nrdiv_sm at N=5 and N=8: directed operations, a
// scoreboard of model results, handshake corner cases and asynchronous reset.
module tb_seq_nrdiv_sm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_nrdiv_sm_if #(.N(5)) bus5 ();
  seq_nrdiv_sm_if #(.N(8)) bus8 ();

  seq_nrdiv_sm #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  seq_nrdiv_sm #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       qs;
    logic       rs;
    logic       dz;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with sign-magnitude rules.
  function automatic exp_t model(input int n, input int x, input int y,
                                 input logic xs, input logic ys);
    exp_t e;
    e.q = '0; e.r = '0; e.qs = 1'b0; e.rs = 1'b0; e.dz = 1'b0; e.ovf = 1'b0;
    e.lat = 2;
    if (y == 0) begin
      e.dz = 1'b1;
    end else if (x / y >= (1 << n)) begin
      e.ovf = 1'b1;
    end else begin
      e.q   = 8'(x / y);
      e.r   = 8'(x % y);
      e.qs  = (xs ^ ys) && (e.q != 0);
      e.rs  = xs && (e.r != 0);
      e.lat = n + 2;
    end
    return e;
  endfunction

  function automatic exp_t observe(input int n);
    exp_t o;
    o.lat = 0;
    if (n == 8) begin
      o.q = bus8.Q; o.r = bus8.R; o.qs = bus8.Q_sign; o.rs = bus8.R_sign;
      o.dz = bus8.div_zero; o.ovf = bus8.ovf;
    end else begin
      o.q = 8'(bus5.Q); o.r = 8'(bus5.R); o.qs = bus5.Q_sign; o.rs = bus5.R_sign;
      o.dz = bus5.div_zero; o.ovf = bus5.ovf;
    end
    return o;
  endfunction

  function automatic logic done_of(input int n);
    return (n == 8) ? bus8.done : bus5.done;
  endfunction

  function automatic logic busy_of(input int n);
    return (n == 8) ? bus8.busy : bus5.busy;
  endfunction

  task automatic drive(input int n, input int x, input int y,
                       input logic xs, input logic ys, input logic st);
    if (n == 8) begin
      bus8.X = 16'(x); bus8.Y = 8'(y); bus8.X_sign = xs; bus8.Y_sign = ys; bus8.start = st;
    end else begin
      bus5.X = 10'(x); bus5.Y = 5'(y); bus5.X_sign = xs; bus5.Y_sign = ys; bus5.start = st;
    end
  endtask

  task automatic set_start(input int n, input logic st);
    if (n == 8) bus8.start = st;
    else        bus5.start = st;
  endtask

  // Waits up to 60 edges for done, sampling 1 time unit after each edge; 0 means timeout.
  task automatic wait_done(input int n, output int edges);
    edges = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done_of(n)) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic compare(input string tag, input int n, input int edges);
    exp_t e;
    exp_t o;
    check({tag, ":done_seen"}, 32'(edges != 0), 32'd1);
    if (sb.size() == 0) begin
      check({tag, ":sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      o = observe(n);
      check({tag, ":latency"}, 32'(edges), 32'(e.lat));
      check({tag, ":Q"},        32'(o.q),   32'(e.q));
      check({tag, ":R"},        32'(o.r),   32'(e.r));
      check({tag, ":Q_sign"},   32'(o.qs),  32'(e.qs));
      check({tag, ":R_sign"},   32'(o.rs),  32'(e.rs));
      check({tag, ":div_zero"}, 32'(o.dz),  32'(e.dz));
      check({tag, ":ovf"},      32'(o.ovf), 32'(e.ovf));
      check({tag, ":busy_low"}, 32'(busy_of(n)), 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input int n, input int x, input int y,
                        input logic xs, input logic ys);
    int edges;
    sb.push_back(model(n, x, y, xs, ys));
    @(negedge clk);
    drive(n, x, y, xs, ys, 1'b1);
    @(posedge clk); #1;
    set_start(n, 1'b0);
    check({tag, ":busy"}, 32'(busy_of(n)), 32'd1);
    wait_done(n, edges);
    compare(tag, n, edges);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 32'(done_of(n)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges;
    int   n_done;
    int   t_first;
    int   t_second;
    exp_t e;

    drive(5, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(8, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy5", 32'(bus5.busy), 32'd0);
    check("rst:done5", 32'(bus5.done), 32'd0);
    check("rst:Q5",    32'(bus5.Q),    32'd0);
    check("rst:R5",    32'(bus5.R),    32'd0);
    check("rst:flags5", 32'({bus5.div_zero, bus5.ovf, bus5.Q_sign, bus5.R_sign}), 32'd0);
    check("rst:Q8",    32'(bus8.Q),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal results, largest non-overflow, overflow, divide-by-zero priority
    run_op("op100_13", 5, 100, 13, 1'b1, 1'b0);
    run_op("op991_31", 5, 991, 31, 1'b0, 1'b0);
    run_op("ovf992_31", 5, 992, 31, 1'b0, 1'b0);
    run_op("dz77_0",   5, 77,  0,  1'b0, 1'b0);
    run_op("dz512_0",  5, 512, 0,  1'b0, 1'b0);
    run_op("op5_9",    5, 5,   9,  1'b1, 1'b0);
    run_op("op18_9",   5, 18,  9,  1'b1, 1'b0);
    run_op("op777_25", 5, 777, 25, 1'b0, 1'b1);

    // Start held high for 10 cycles: one op, then a back-to-back op from DONE
    sb.push_back(model(5, 100, 13, 1'b1, 1'b0));
    sb.push_back(model(5, 100, 13, 1'b1, 1'b0));
    n_done   = 0;
    t_first  = -1;
    t_second = -1;
    @(negedge clk);
    drive(5, 100, 13, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 9) set_start(5, 1'b0);
      if (bus5.done) begin
        n_done++;
        if (n_done == 1) t_first = k;
        if (n_done == 2) t_second = k;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("hold:Q", 32'(bus5.Q), 32'(e.q));
          check("hold:R", 32'(bus5.R), 32'(e.r));
        end
      end
    end
    check("hold:n_done",   32'(n_done),   32'd2);
    check("hold:t_first",  32'(t_first),  32'd7);
    check("hold:t_second", 32'(t_second), 32'd15);

    // A start pulse with new operands during ITER is ignored
    sb.push_back(model(5, 991, 31, 1'b0, 1'b0));
    @(negedge clk);
    drive(5, 991, 31, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(5, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    drive(5, 500, 3, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_start(5, 1'b0);
    wait_done(5, edges);
    compare("ign_mid", 5, (edges == 0) ? 0 : edges + 4);

    // Asynchronous reset mid-ITER clears outputs at once and suppresses done
    @(negedge clk);
    drive(5, 100, 13, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_start(5, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("arst:busy_before", 32'(bus5.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst:busy", 32'(bus5.busy), 32'd0);
    check("arst:Q",    32'(bus5.Q),    32'd0);
    check("arst:R",    32'(bus5.R),    32'd0);
    check("arst:misc", 32'({bus5.done, bus5.Q_sign, bus5.R_sign, bus5.div_zero, bus5.ovf}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus5.done) n_done++;
    end
    check("arst:no_done", 32'(n_done), 32'd0);

    run_op("post_rst", 5, 100, 13, 1'b0, 1'b1);
    run_op("n8_65000_255", 8, 65000, 255, 1'b0, 1'b0);
    run_op("n8_ovf", 8, 65280, 255, 1'b1, 1'b0);
    run_op("n8_signed", 8, 40000, 200, 1'b1, 1'b1);

    check("sb:empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
